sys_ctrl: RTL
=============

# sys_ctrl

Command-level controller between the byte-stream receiver and the register file / ALU datapath. It parses incoming `dataframe_t` command frames and issues register-file reads and writes. It loads ALU operands, launches the selected `opcode_t` operation, and returns results as byte frames over a valid/ready transmit handshake. It is the only master of the register file and the ALU in the system.

## Interface

**Parameters**
- `ADDR_W`, default 4: register-file address width. Addresses 0 and 1 are the ALU operand registers A and B.

**Ports**
- `clk`, in, 1: system clock; all state changes on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `rx_data`, in, 8 (`dataframe_t`): received byte.
- `rx_valid`, in, 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `rf_addr`, out, `ADDR_W`: register-file address.
- `rf_wr_en`, out, 1: one-cycle write strobe.
- `rf_wr_data`, out, 8: write data.
- `rf_rd_en`, out, 1: one-cycle read strobe.
- `rf_rd_data`, in, 8: read data.
- `rf_rd_valid`, in, 1: read data valid; arrives 1 or more cycles after `rf_rd_en`.
- `alu_en`, out, 1: one-cycle ALU start strobe.
- `alu_fun`, out, 4 (`opcode_t`): ALU operation.
- `alu_out`, in, 16: ALU result.
- `alu_valid`, in, 1: result valid.
- `tx_data`, out, 8: response byte.
- `tx_valid`, out, 1: response byte offered.
- `tx_ready`, in, 1: transmitter accepts the byte.
- `busy`, out, 1: high in any state other than the idle and frame-collection states.

## Operation

- Command bytes, accepted in `IDLE` only:
  - `0xAA` RF write: followed by addr, data.
  - `0xBB` RF read: followed by addr.
  - `0xCC` ALU with operands: followed by A, B, fun.
  - `0xDD` ALU without operands: followed by fun.
- Any other byte in `IDLE` is ignored. The FSM stays in `IDLE`.
- Address bytes use bits `[ADDR_W-1:0]`; upper bits are ignored.
- **RF write:** `IDLE → WR_ADDR → WR_DATA`. On the data byte, pulse `rf_wr_en` for 1 cycle with the latched addr and data, then return to `IDLE`. No response is sent.
- **RF read:** `IDLE → RD_ADDR`. On the addr byte, pulse `rf_rd_en` for 1 cycle and go to `RD_WAIT`. On `rf_rd_valid`, latch `rf_rd_data` and go to `TX_RD`. Send 1 byte, then return to `IDLE`.
- **ALU with operands (`0xCC`):** `IDLE → OPA → OPB → FUN`.
  - The A byte is written to address 0.
  - The B byte is written to address 1.
  - Each write is a 1-cycle `rf_wr_en` pulse in the cycle after the byte arrives.
- **FUN state (both ALU commands):**
  - If fun ≤ 13: latch it into `alu_fun`, pulse `alu_en` for 1 cycle, go to `ALU_WAIT`.
  - If fun > 13: go to `TX_ERR` and send the single byte `0xEE`. The ALU is not started.
- **ALU_WAIT:** on `alu_valid`, latch `alu_out` and go to `TX_LO`, then `TX_HI`. The low byte `[7:0]` is sent first, then the high byte `[15:8]`. Then return to `IDLE`.
- `rx_valid` in `RD_WAIT`, `ALU_WAIT`, or any `TX_*` state: the byte is dropped and `busy` = 1. There is no queuing.
- Reset values: all strobes 0, `tx_valid` 0, `tx_data` 0x00, `rf_addr` 0, `rf_wr_data` 0, `alu_fun` `OP_ADD`, `busy` 0, state `IDLE`.
- Reset asserted mid-command discards the partial frame and any pending response.

## Timing

- Each state advances only on `rx_valid`, `rf_rd_valid`, `alu_valid`, or a completed tx handshake. There are no timeouts.
- `rf_wr_en`, `rf_rd_en` and `alu_en` are registered. Each is high exactly one cycle, starting the cycle after the triggering byte.
- In `OPB`, the write of B and the FUN-state entry occur in the same cycle. `alu_en` cannot assert before that write cycle.
- Tx handshake rules:
  - `tx_valid` and `tx_data` are registered and held stable until the cycle where `tx_valid && tx_ready`.
  - The next byte, or a return to `IDLE`, follows in the next cycle.
  - `tx_valid` never drops without a handshake.
- `tx_ready` held high: a 2-byte ALU response occupies exactly 2 consecutive `tx_valid` cycles.
- Minimum latency for RF write: 1 cycle from the data-byte strobe to `rf_wr_en`.
- Minimum latency for `0xDD`: 1 cycle from the fun-byte strobe to `alu_en`.

## Structure

- Shared package additions:
  - `cmd_t` enum with `CMD_RF_WR`=`0xAA`, `CMD_RF_RD`=`0xBB`, `CMD_ALU_OP`=`0xCC`, `CMD_ALU_NOP`=`0xDD`.
  - `ERR_BYTE` = `0xEE`.
  - `alu_result_t` = `logic [15:0]`.
- Keep the FSM state enum local to the module.
- Single module; no sub-module. The FSM, operand/addr latches and tx output register all live in `sys_ctrl`.

## Test plan

- **RF write then read:** `AA 05 3C`, then `BB 05`.
  - Expect `rf_wr_en` with addr 5 and data `0x3C`.
  - Expect a read of addr 5; with the RF model returning `0x3C`, a single tx byte `0x3C`.
- **ALU with operands:** `CC 0A 03 02` (`OP_MULT`).
  - Expect writes of `0x0A` to addr 0 and `0x03` to addr 1.
  - Expect `alu_en` with `alu_fun`=2.
  - With the model returning `0x001E`, expect tx bytes `1E`, then `00`.
- **Invalid opcode:** `DD 0F` → tx byte `0xEE`; `alu_en` never asserts.
- **Backpressure:** hold `tx_ready`=0 for 5 cycles during an ALU response → `tx_data` is stable at the low byte and `tx_valid` stays 1. On release, both bytes complete in order.
- **Busy drop and unknown command:**
  - `rx_valid` with `0xAA` during `ALU_WAIT` → ignored; `busy`=1; no RF write.
  - `0x55` in `IDLE` → FSM stays in `IDLE`.
- **Reset mid-frame:** `CC 01` then `rst_n` low → all outputs return to reset values. A subsequent `BB 00` behaves normally.

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sys_ctrl_pkg
// Description : Shared types for the command controller: byte frames, ALU
//               opcodes, command codes, error byte and ALU result type.
// Revision    : 1.0 - initial release
// ============================================================================
package sys_ctrl_pkg;

  typedef logic [7:0]  dataframe_t;
  typedef logic [15:0] alu_result_t;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_MULT  = 4'd2,
    OP_DIV   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_NAND  = 4'd6,
    OP_NOR   = 4'd7,
    OP_XOR   = 4'd8,
    OP_XNOR  = 4'd9,
    OP_CMPEQ = 4'd10,
    OP_CMPGT = 4'd11,
    OP_SHR   = 4'd12,
    OP_SHL   = 4'd13
  } opcode_t;

  typedef enum logic [7:0] {
    CMD_RF_WR   = 8'hAA,
    CMD_RF_RD   = 8'hBB,
    CMD_ALU_OP  = 8'hCC,
    CMD_ALU_NOP = 8'hDD
  } cmd_t;

  localparam dataframe_t ERR_BYTE    = 8'hEE;
  localparam dataframe_t ALU_FUN_MAX = 8'd13;

  // The whole byte is compared, so 0x12 is rejected even though its low
  // nibble would be a legal opcode.
  function automatic logic fun_is_valid(input dataframe_t fun);
    return (fun <= ALU_FUN_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sys_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sys_ctrl
// Description : Command-level controller. Parses received command frames,
//               drives register-file reads/writes, starts the ALU and returns
//               results as bytes over a valid/ready transmit handshake.
// Revision    : 1.0 - initial release
//
// Ports
//   clk, rst_n               : clock, asynchronous active-low reset
//   rx_data, rx_valid        : received byte and its one-cycle strobe
//   rf_addr                  : register-file address (0 = A, 1 = B)
//   rf_wr_en, rf_wr_data     : one-cycle write strobe and data
//   rf_rd_en                 : one-cycle read strobe
//   rf_rd_data, rf_rd_valid  : read return data and its valid
//   alu_en, alu_fun          : one-cycle ALU start strobe and operation
//   alu_out, alu_valid       : ALU result and its valid
//   tx_data, tx_valid        : response byte offered to the transmitter
//   tx_ready                 : transmitter accepts the byte
//   busy                     : high outside idle and frame-collection states
// ============================================================================
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  dataframe_t        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_wr_en,
  output dataframe_t        rf_wr_data,
  output logic              rf_rd_en,
  input  dataframe_t        rf_rd_data,
  input  logic              rf_rd_valid,
  output logic              alu_en,
  output opcode_t           alu_fun,
  input  alu_result_t       alu_out,
  input  logic              alu_valid,
  output dataframe_t        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_ADDR  = 4'd1,
    ST_WR_DATA  = 4'd2,
    ST_RD_ADDR  = 4'd3,
    ST_RD_WAIT  = 4'd4,
    ST_TX_RD    = 4'd5,
    ST_OPA      = 4'd6,
    ST_OPB      = 4'd7,
    ST_FUN      = 4'd8,
    ST_ALU_WAIT = 4'd9,
    ST_TX_LO    = 4'd10,
    ST_TX_HI    = 4'd11,
    ST_TX_ERR   = 4'd12
  } state_t;

  localparam logic [ADDR_W-1:0] c_ADDR_A = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] c_ADDR_B = ADDR_W'(1);

  state_t            r_state,      w_state_nxt;
  logic [ADDR_W-1:0] r_rf_addr,    w_rf_addr_nxt;
  dataframe_t        r_rf_wr_data, w_rf_wr_data_nxt;
  logic              r_rf_wr_en,   w_rf_wr_en_nxt;
  logic              r_rf_rd_en,   w_rf_rd_en_nxt;
  logic              r_alu_en,     w_alu_en_nxt;
  opcode_t           r_alu_fun,    w_alu_fun_nxt;
  dataframe_t        r_tx_data,    w_tx_data_nxt;
  logic              r_tx_valid,   w_tx_valid_nxt;
  dataframe_t        r_res_hi,     w_res_hi_nxt;
  logic              w_tx_fire;

  assign w_tx_fire = r_tx_valid && tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_rf_addr    <= '0;
      r_rf_wr_data <= '0;
      r_rf_wr_en   <= 1'b0;
      r_rf_rd_en   <= 1'b0;
      r_alu_en     <= 1'b0;
      r_alu_fun    <= OP_ADD;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_res_hi     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rf_addr    <= w_rf_addr_nxt;
      r_rf_wr_data <= w_rf_wr_data_nxt;
      r_rf_wr_en   <= w_rf_wr_en_nxt;
      r_rf_rd_en   <= w_rf_rd_en_nxt;
      r_alu_en     <= w_alu_en_nxt;
      r_alu_fun    <= w_alu_fun_nxt;
      r_tx_data    <= w_tx_data_nxt;
      r_tx_valid   <= w_tx_valid_nxt;
      r_res_hi     <= w_res_hi_nxt;
    end
  end

  // Next-state logic also computes the next value of every registered
  // output, so strobes land exactly one cycle after their trigger.
  always_comb begin
    w_state_nxt      = r_state;
    w_rf_addr_nxt    = r_rf_addr;
    w_rf_wr_data_nxt = r_rf_wr_data;
    w_rf_wr_en_nxt   = 1'b0;
    w_rf_rd_en_nxt   = 1'b0;
    w_alu_en_nxt     = 1'b0;
    w_alu_fun_nxt    = r_alu_fun;
    w_tx_data_nxt    = r_tx_data;
    w_tx_valid_nxt   = r_tx_valid;
    w_res_hi_nxt     = r_res_hi;

    case (r_state)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_RF_WR)        w_state_nxt = ST_WR_ADDR;
          else if (rx_data == CMD_RF_RD)   w_state_nxt = ST_RD_ADDR;
          else if (rx_data == CMD_ALU_OP)  w_state_nxt = ST_OPA;
          else if (rx_data == CMD_ALU_NOP) w_state_nxt = ST_FUN;
        end
      end
      ST_WR_ADDR: begin
        if (rx_valid) begin
          w_rf_addr_nxt = rx_data[ADDR_W-1:0];
          w_state_nxt   = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (rx_valid) begin
          w_rf_wr_data_nxt = rx_data;
          w_rf_wr_en_nxt   = 1'b1;
          w_state_nxt      = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (rx_valid) begin
          w_rf_addr_nxt  = rx_data[ADDR_W-1:0];
          w_rf_rd_en_nxt = 1'b1;
          w_state_nxt    = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        // Read data goes straight into the tx register; no extra latch.
        if (rf_rd_valid) begin
          w_tx_data_nxt  = rf_rd_data;
          w_tx_valid_nxt = 1'b1;
          w_state_nxt    = ST_TX_RD;
        end
      end
      ST_OPA: begin
        if (rx_valid) begin
          w_rf_addr_nxt    = c_ADDR_A;
          w_rf_wr_data_nxt = rx_data;
          w_rf_wr_en_nxt   = 1'b1;
          w_state_nxt      = ST_OPB;
        end
      end
      ST_OPB: begin
        // The B write strobe coincides with entry to FUN, so alu_en can
        // never precede the operand write.
        if (rx_valid) begin
          w_rf_addr_nxt    = c_ADDR_B;
          w_rf_wr_data_nxt = rx_data;
          w_rf_wr_en_nxt   = 1'b1;
          w_state_nxt      = ST_FUN;
        end
      end
      ST_FUN: begin
        if (rx_valid) begin
          if (fun_is_valid(rx_data)) begin
            w_alu_fun_nxt = opcode_t'(rx_data[3:0]);
            w_alu_en_nxt  = 1'b1;
            w_state_nxt   = ST_ALU_WAIT;
          end else begin
            w_tx_data_nxt  = ERR_BYTE;
            w_tx_valid_nxt = 1'b1;
            w_state_nxt    = ST_TX_ERR;
          end
        end
      end
      ST_ALU_WAIT: begin
        if (alu_valid) begin
          w_tx_data_nxt  = alu_out[7:0];
          w_res_hi_nxt   = alu_out[15:8];
          w_tx_valid_nxt = 1'b1;
          w_state_nxt    = ST_TX_LO;
        end
      end
      ST_TX_LO: begin
        // tx_valid stays high so the high byte follows back-to-back.
        if (w_tx_fire) begin
          w_tx_data_nxt = r_res_hi;
          w_state_nxt   = ST_TX_HI;
        end
      end
      ST_TX_RD, ST_TX_HI, ST_TX_ERR: begin
        if (w_tx_fire) begin
          w_tx_valid_nxt = 1'b0;
          w_state_nxt    = ST_IDLE;
        end
      end
      default: begin
        w_tx_valid_nxt = 1'b0;
        w_state_nxt    = ST_IDLE;
      end
    endcase
  end

  assign rf_addr    = r_rf_addr;
  assign rf_wr_en   = r_rf_wr_en;
  assign rf_wr_data = r_rf_wr_data;
  assign rf_rd_en   = r_rf_rd_en;
  assign alu_en     = r_alu_en;
  assign alu_fun    = r_alu_fun;
  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;

  assign busy = !(r_state inside {ST_IDLE, ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR,
                                  ST_OPA, ST_OPB, ST_FUN});

endmodule
`default_nettype wire
